rle_encoder: RTL
================

// Module: rle_encoder
// PURPOSE
//  Optional run-length compressor between sampler (dataOut/validOut) and sample_fifo (data_in/en).
//  Bypass: samples pass through unchanged, 1-cycle latency. RLE mode: repeated samples
//  collapse into count words, extending capture depth for slowly changing inputs.
//  Controller drives rle_en and flush; FIFO write strobe comes from valid_out.
// PARAMETERS
//  SAMPLE_WIDTH  8  sample/word width; in RLE mode MSB is the count flag, data uses SAMPLE_WIDTH-1 bits
// PORTS
//  clock      in   1               system clock
//  reset      in   1               asynchronous, active-high
//  rle_en     in   1               1 = RLE mode, 0 = bypass
//  flush      in   1               1-cycle pulse: emit pending run count (end of capture)
//  data_in    in   SAMPLE_WIDTH    sample from sampler
//  valid_in   in   1               sample strobe, at most one per cycle
//  data_out   out  SAMPLE_WIDTH    word to sample_fifo
//  valid_out  out  1               word strobe, at most one per cycle
//  overflow   out  1               sticky: output queue overflowed, word dropped
// BEHAVIOUR
//  Reset: data_out=0, valid_out=0, overflow=0; queue empty; run count=0; last-value invalid.
//  Bypass (rle_en=0): data_out<=data_in, valid_out<=valid_in, next edge; queue unused.
//  RLE word formats: value word {1'b0, d[SAMPLE_WIDTH-2:0]}; count word {1'b1, N}, N = additional repeats.
//  RLE input handling on valid_in (d = data_in with MSB forced 0):
//   - last-value invalid: enqueue value word d; last<=d; valid; count<=0.
//   - d==last: count<=count+1; at count==2^(SAMPLE_WIDTH-1)-1 (127) enqueue count word, count<=0.
//   - d!=last: if count>0 enqueue count word then value word d (same cycle, that order);
//     else value word d only; last<=d; count<=0.
//  flush (RLE mode): after same-cycle valid_in processing, if count>0 enqueue count word, count<=0;
//   last-value -> invalid, so next sample always starts with a value word. flush with count==0: no word.
//  Output queue: 2 entries, FIFO order; up to 2 enqueues/cycle; head pops to data_out with
//   valid_out=1 one word per cycle, no backpressure (pop happens before enqueue each cycle).
//  Latency: value word on queue-empty appears 1 cycle after valid_in; count+value pair at +1 and +2.
//  Queue cannot overflow for legal input (each repeat cycle drains one slot); if an enqueue
//   finds no slot the word is dropped, overflow<=1 (sticky until reset).
//  rle_en 1->0: run state discarded (count=0, last invalid, pending count NOT emitted);
//   queued words still drain before bypass words; bypass word waits behind them (no loss).
//  rle_en 0->1: starts with last invalid. Counter arithmetic: SAMPLE_WIDTH-1 bits, never wraps
//   (emitted at max). Reset mid-run: everything cleared immediately, queued words lost.
// CONFIGURATION
//  RLE_STATS_EN defined: add outputs words_in[15:0] (valid_in count) and words_out[15:0]
//   (valid_out count), both saturating at 16'hFFFF, cleared by reset and by flush.
//  Undefined: no extra ports or logic; all other behaviour identical.
// TESTING
//  Bypass: rle_en=0, 0x12,0x34 back-to-back -> 0x12,0x34 on valid_out, each 1 cycle later.
//  Run: rle_en=1, 0x05 x4 then 0x06 -> 0x05, 0x83, 0x06; then flush -> no further word.
//  Saturation: 0x01 x130 then flush -> 0x01, 0xFF (127 repeats), 0x82 (2 repeats).
//  Alternating every cycle 0x01/0x02 x20, plus runs of 2 interleaved -> no drop, overflow=0.
//  Flush+repeat same cycle: 0x07,0x07 with flush on 2nd -> 0x07, 0x81; next 0x07 -> value 0x07.
//  Reset asserted mid-run with queue non-empty -> valid_out=0 same cycle, overflow=0, no stale word.

Source files
------------

// File: rtl/rle_encoder.sv
// Run-length encoder between sampler and sample FIFO, with bypass mode and a 2-entry output queue.
// Optional RLE_STATS_EN macro adds saturating words_in/words_out counters.
module rle_encoder #(
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rle_en,
  input  logic                    flush,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic [SAMPLE_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    overflow
`ifdef RLE_STATS_EN
  ,
  output logic [15:0]             words_in,
  output logic [15:0]             words_out
`endif
);
  localparam int CW = SAMPLE_WIDTH - 1;
  localparam logic [CW-1:0] CMAX    = '1;
  localparam logic [CW-1:0] CMAX_M1 = CMAX - 1'b1;

  logic [CW-1:0]           last, last_n, cnt, cnt_n, d;
  logic                    last_v, lv_n;
  logic [SAMPLE_WIDTH-1:0] q0, q1;
  logic [1:0]              qn;

  logic [SAMPLE_WIDTH-1:0] wq [2];
  logic [1:0]              nw;
  logic [SAMPLE_WIDTH-1:0] lst [3];
  logic [2:0]              ln;

  assign d = data_in[CW-1:0];

  // New words generated this cycle (at most two).
  always_comb begin
    wq[0]  = '0;
    wq[1]  = '0;
    nw     = 2'd0;
    cnt_n  = cnt;
    last_n = last;
    lv_n   = last_v;
    if (rle_en) begin
      if (valid_in) begin
        if (!last_v) begin
          wq[nw[0]] = {1'b0, d}; nw = nw + 2'd1;
          last_n = d; lv_n = 1'b1; cnt_n = '0;
        end else if (d == last) begin
          if (cnt == CMAX_M1) begin
            wq[nw[0]] = {1'b1, CMAX}; nw = nw + 2'd1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          if (cnt != '0) begin
            wq[nw[0]] = {1'b1, cnt}; nw = nw + 2'd1;
          end
          wq[nw[0]] = {1'b0, d}; nw = nw + 2'd1;
          last_n = d; cnt_n = '0;
        end
      end
      // Flush is applied after this cycle's sample has been folded in.
      if (flush) begin
        if (cnt_n != '0) begin
          wq[nw[0]] = {1'b1, cnt_n}; nw = nw + 2'd1;
        end
        cnt_n = '0;
        lv_n  = 1'b0;
      end
    end else begin
      cnt_n = '0;
      lv_n  = 1'b0;
      if (valid_in) begin
        wq[0] = data_in; nw = 2'd1;
      end
    end
  end

  // Queued words followed by new words; lst[0] is what leaves this cycle.
  always_comb begin
    lst[0] = q0;
    lst[1] = q1;
    lst[2] = '0;
    ln     = {1'b0, qn};
    if (nw != 2'd0) begin
      if (ln < 3'd3) lst[ln[1:0]] = wq[0];
      ln = ln + 3'd1;
    end
    if (nw == 2'd2) begin
      if (ln < 3'd3) lst[ln[1:0]] = wq[1];
      ln = ln + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      last      <= '0;
      last_v    <= 1'b0;
      cnt       <= '0;
      q0        <= '0;
      q1        <= '0;
      qn        <= 2'd0;
    end else begin
      last   <= last_n;
      last_v <= lv_n;
      cnt    <= cnt_n;
      if (ln != 3'd0) begin
        data_out  <= lst[0];
        valid_out <= 1'b1;
        q0        <= lst[1];
        q1        <= lst[2];
        qn        <= (ln == 3'd4) ? 2'd2 : 2'(ln - 3'd1);
        if (ln == 3'd4) overflow <= 1'b1;
      end else begin
        valid_out <= 1'b0;
        qn        <= 2'd0;
        if (!rle_en) data_out <= data_in;
      end
    end
  end

`ifdef RLE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      words_in  <= '0;
      words_out <= '0;
    end else if (flush) begin
      words_in  <= '0;
      words_out <= '0;
    end else begin
      if (valid_in && words_in != 16'hFFFF)   words_in  <= words_in + 16'd1;
      if (valid_out && words_out != 16'hFFFF) words_out <= words_out + 16'd1;
    end
  end
`endif

endmodule
